// File: rtl/ysyx_22040759_inst_fetch.sv
// ysyx_22040759_inst_fetch: instruction fetch unit with a one-entry line buffer
//   clk/rst                                  clock, asynchronous active-low reset
//   req_valid/req_ready/req_addr             fetch request handshake and byte address
//   resp_valid/resp_ready/resp_inst/resp_err fetch response handshake, instruction, misalignment flag
//   flush                                    invalidates the line buffer
//   mem_req_valid/mem_req_ready/mem_req_addr word-aligned memory read request
//   mem_resp_valid/mem_resp_data             memory read data
module ysyx_22040759_inst_fetch #(
   parameter int AW = 64,
   parameter int DW = 64,
   parameter int IW = 32,
   parameter bit BUF_EN = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [AW-1:0] req_addr,
   output logic          resp_valid,
   input  logic          resp_ready,
   output logic [IW-1:0] resp_inst,
   output logic          resp_err,
   input  logic          flush,
   output logic          mem_req_valid,
   input  logic          mem_req_ready,
   output logic [AW-1:0] mem_req_addr,
   input  logic          mem_resp_valid,
   input  logic [DW-1:0] mem_resp_data
);
   localparam int OB = $clog2(DW / 8);
   localparam logic [1:0] IDLE = 2'd0, MEM_REQ = 2'd1, MEM_WAIT = 2'd2, RESP = 2'd3;
   logic [1:0] state;
   logic [AW-1:0] addr_q;
   logic [AW-OB-1:0] buf_tag;
   logic [DW-1:0] buf_data;
   logic buf_valid, kill, err_q, misaligned, hit;
   logic [IW-1:0] inst_q;
   // lane index is the 32-bit slot within the word: addr[OB-1:2]
   function automatic logic [IW-1:0] pick(input logic [DW-1:0] w, input logic [AW-1:0] a);
      return IW'(w >> (IW * (int'(a[OB-1:0]) >> 2)));
   endfunction
   assign req_ready = rst && state == IDLE;
   assign resp_valid = state == RESP;
   assign resp_inst = inst_q;
   assign resp_err = err_q;
   assign mem_req_valid = state == MEM_REQ;
   assign mem_req_addr = {addr_q[AW-1:OB], {OB{1'b0}}};
   assign misaligned = req_addr[1:0] != 2'b00;
   // a same-cycle flush makes the lookup see an invalid buffer
   assign hit = BUF_EN && buf_valid && !flush && buf_tag == req_addr[AW-1:OB];
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         addr_q <= '0;
         buf_tag <= '0;
         buf_data <= '0;
         buf_valid <= 1'b0;
         kill <= 1'b0;
         inst_q <= '0;
         err_q <= 1'b0;
      end else begin
         if (flush) buf_valid <= 1'b0;
         // kill keeps a word fetched across a flush out of the buffer
         if (flush && (state == MEM_REQ || state == MEM_WAIT)) kill <= 1'b1;
         else if (state == IDLE) kill <= 1'b0;
         case (state)
            IDLE: if (req_valid) begin
               addr_q <= req_addr;
               if (misaligned) begin
                  state <= RESP;
                  inst_q <= '0;
                  err_q <= 1'b1;
               end else if (hit) begin
                  state <= RESP;
                  inst_q <= pick(buf_data, req_addr);
                  err_q <= 1'b0;
               end else state <= MEM_REQ;
            end
            MEM_REQ: if (mem_req_ready) state <= MEM_WAIT;
            MEM_WAIT: if (mem_resp_valid) begin
               state <= RESP;
               inst_q <= pick(mem_resp_data, addr_q);
               err_q <= 1'b0;
               if (BUF_EN && !kill && !flush) begin
                  buf_tag <= addr_q[AW-1:OB];
                  buf_data <= mem_resp_data;
                  buf_valid <= 1'b1;
               end
            end
            default: if (resp_ready) state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ysyx_22040759_inst_fetch.sv
// tb_ysyx_22040759_inst_fetch: checks a buffered and an unbuffered fetch unit against a behavioural model
module tb_ysyx_22040759_inst_fetch;
   logic clk = 1'b0, rst = 1'b0;
   always #5 clk = ~clk;
   logic req_valid[2], req_ready[2], resp_valid[2], resp_ready[2], resp_err[2], flush[2];
   logic mem_req_valid[2], mem_req_ready[2], mem_resp_valid[2];
   logic [63:0] req_addr[2], mem_req_addr[2], mem_resp_data[2];
   logic [31:0] resp_inst[2];
   int checks = 0, failures = 0;
   int nreads[2], lat[2], cnt[2];
   logic [63:0] last_addr[2], pa[2], ba[2];
   bit bv[2];
   ysyx_22040759_inst_fetch #(.AW(64), .DW(64), .IW(32), .BUF_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
      .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_inst(resp_inst[0]), .resp_err(resp_err[0]),
      .flush(flush[0]), .mem_req_valid(mem_req_valid[0]), .mem_req_ready(mem_req_ready[0]),
      .mem_req_addr(mem_req_addr[0]), .mem_resp_valid(mem_resp_valid[0]), .mem_resp_data(mem_resp_data[0]));
   ysyx_22040759_inst_fetch #(.AW(64), .DW(64), .IW(32), .BUF_EN(1'b0)) dut_nobuf (
      .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
      .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_inst(resp_inst[1]), .resp_err(resp_err[1]),
      .flush(flush[1]), .mem_req_valid(mem_req_valid[1]), .mem_req_ready(mem_req_ready[1]),
      .mem_req_addr(mem_req_addr[1]), .mem_resp_valid(mem_resp_valid[1]), .mem_resp_data(mem_resp_data[1]));
   function automatic logic [63:0] word(input logic [63:0] a);
      return a == 64'h80000000 ? 64'h00000297_00100073 : {a[31:0] ^ 32'hA5A5_0F0F, a[31:0] + 32'h1357_9BDF};
   endfunction
   function automatic logic [31:0] lanesel(input logic [63:0] w, input logic [63:0] a);
      logic [63:0] s;
      s = w >> (32 * ((a % 8) / 4));
      return s[31:0];
   endfunction
   // memory: answers lat cycles after each accepted read
   always @(posedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (!rst) begin
            cnt[g] = 0;
            mem_resp_valid[g] <= 1'b0;
         end else begin
            mem_resp_valid[g] <= 1'b0;
            if (mem_req_valid[g] && mem_req_ready[g]) begin
               cnt[g] = lat[g];
               pa[g] = mem_req_addr[g];
               nreads[g]++;
               last_addr[g] = mem_req_addr[g];
            end else if (cnt[g] > 0) begin
               cnt[g]--;
               if (cnt[g] == 0) begin
                  mem_resp_valid[g] <= 1'b1;
                  mem_resp_data[g] <= word(pa[g]);
               end
            end
         end
      end
   end
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   // fm: 0 none, 1 flush with the request, 2 flush once the memory read is accepted
   task automatic fetch(input int d, input logic [63:0] a, input int fm, input int ms, input int rs);
      logic [63:0] al;
      logic [31:0] ei;
      bit mis, hit, seen, fdone, got;
      int n0, cyc, mcnt;
      al = a & ~64'h7;
      mis = (a % 4) != 0;
      hit = !mis && d == 0 && bv[d] && ba[d] == al && fm != 1;
      ei = mis ? 32'h0 : lanesel(word(al), a);
      seen = 0; fdone = 0; got = 0; cyc = 0; mcnt = 0;
      @(negedge clk);
      chk("req_ready_idle", 64'(req_ready[d]), 64'd1);
      n0 = nreads[d];
      req_valid[d] = 1'b1; req_addr[d] = a; flush[d] = fm == 1; mem_req_ready[d] = ms == 0;
      @(negedge clk);
      req_valid[d] = 1'b0; flush[d] = 1'b0;
      cyc = 1;
      while (!got && cyc < 60) begin
         if (resp_valid[d]) got = 1;
         else begin
            chk("req_ready_busy", 64'(req_ready[d]), 64'd0);
            flush[d] = 1'b0;
            if (mem_req_valid[d]) begin
               seen = 1;
               chk("mem_req_addr", mem_req_addr[d], al);
               mcnt++;
               if (mcnt >= ms) mem_req_ready[d] = 1'b1;
            end else if (seen && !fdone && fm == 2) begin
               flush[d] = 1'b1;
               fdone = 1;
            end
            @(negedge clk);
            cyc++;
         end
      end
      flush[d] = 1'b0; mem_req_ready[d] = 1'b1;
      chk("resp_timeout", 64'(got), 64'd1);
      if (got) begin
         if (hit || mis) begin
            chk("short_latency", 64'(cyc), 64'd1);
            chk("no_mem_req", 64'(seen), 64'd0);
         end
         chk("resp_inst", 64'(resp_inst[d]), 64'(ei));
         chk("resp_err", 64'(resp_err[d]), 64'(mis));
         if (rs > 0) begin
            resp_ready[d] = 1'b0;
            repeat (rs) begin
               @(negedge clk);
               chk("resp_hold_valid", 64'(resp_valid[d]), 64'd1);
               chk("resp_hold_inst", 64'(resp_inst[d]), 64'(ei));
               chk("resp_hold_ready", 64'(req_ready[d]), 64'd0);
            end
            resp_ready[d] = 1'b1;
         end
         @(negedge clk);
         chk("resp_done", {62'd0, resp_valid[d], req_ready[d]}, 64'd1);
      end
      chk("mem_reads", 64'(nreads[d] - n0), (hit || mis) ? 64'd0 : 64'd1);
      if (!hit && !mis) chk("mem_last_addr", last_addr[d], al);
      if (fm == 1) bv[d] = 0;
      if (!mis && !hit) begin
         bv[d] = fm != 2;
         ba[d] = al;
      end
   endtask
   initial begin
      for (int g = 0; g < 2; g++) begin
         req_valid[g] = 1'b0; req_addr[g] = '0; resp_ready[g] = 1'b1; flush[g] = 1'b0;
         mem_req_ready[g] = 1'b1; nreads[g] = 0; lat[g] = 1; bv[g] = 0; ba[g] = '0;
      end
      repeat (3) @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         chk("reset_ctl", {60'd0, req_ready[g], resp_valid[g], resp_err[g], mem_req_valid[g]}, 64'd0);
         chk("reset_inst", 64'(resp_inst[g]), 64'd0);
         chk("reset_addr", mem_req_addr[g], 64'd0);
      end
      rst = 1'b1;
      fetch(0, 64'h80000000, 0, 0, 0);
      fetch(0, 64'h80000004, 0, 0, 0);
      fetch(0, 64'h80000002, 0, 0, 0);
      fetch(0, 64'h80000008, 0, 4, 3);
      lat[0] = 2;
      fetch(0, 64'h80000010, 2, 0, 0);
      lat[0] = 1;
      fetch(0, 64'h80000014, 0, 0, 0);
      fetch(0, 64'h80000010, 1, 0, 0);
      fetch(1, 64'h80000000, 0, 0, 0);
      fetch(1, 64'h80000004, 0, 0, 0);
      fetch(0, 64'h80000020, 0, 0, 0);
      lat[0] = 4;
      @(negedge clk);
      req_valid[0] = 1'b1; req_addr[0] = 64'h80000030;
      @(negedge clk);
      req_valid[0] = 1'b0;
      @(negedge clk);
      chk("pre_reset_wait", {62'd0, mem_req_valid[0], resp_valid[0]}, 64'd0);
      rst = 1'b0;
      #1;
      chk("async_reset_ctl", {60'd0, req_ready[0], resp_valid[0], resp_err[0], mem_req_valid[0]}, 64'd0);
      chk("async_reset_inst", 64'(resp_inst[0]), 64'd0);
      chk("async_reset_addr", mem_req_addr[0], 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      bv[0] = 0; bv[1] = 0; lat[0] = 1;
      fetch(0, 64'h80000024, 0, 0, 0);
      for (int i = 0; i < 40; i++) begin
         int d;
         logic [63:0] a;
         d = int'($urandom_range(0, 1));
         a = 64'h80000000 + 64'(4 * $urandom_range(0, 15)) + (($urandom_range(0, 5) == 0) ? 64'd2 : 64'd0);
         lat[d] = int'($urandom_range(1, 3));
         fetch(d, a, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
